// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration write arbiter:
// register map, bank size and the write-request bundle.
package cfg_pkg;

    localparam int NUM_CFG_REGS = 5;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [6:0] ADDR_DUTY      = 7'd4;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } cfg_wr_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant with the last-grant pointer.
// Grant is combinational; the pointer moves on every acceptance.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end else if (req_i[0]) begin
            gnt_o = 2'b01;
        end else if (req_i[1]) begin
            gnt_o = 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (|gnt_o) last_d = gnt_o[1];
    end

    // Pointer resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/cfg_write_arbiter.sv
// Two-port config writer with shadow bank; shadow is copied to the
// active PWM/output registers atomically at period boundaries.
module cfg_write_arbiter
    import cfg_pkg::*;
#(
    parameter logic [6:0] MAX_ADDRESS      = 7'h04,
    parameter bit         COMMIT_ON_PERIOD = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    input  logic       period_start,
    input  logic       err_clear,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       pending,
    output logic       err_addr,
    output logic       err_src
);

    logic [1:0] gnt;
    cfg_wr_t    wr;
    logic       acc;
    logic       in_rng;
    logic       commit;
    logic [2:0] widx;

    logic [7:0] shadow_q [NUM_CFG_REGS];
    logic [7:0] shadow_d [NUM_CFG_REGS];
    logic [7:0] active_q [NUM_CFG_REGS];
    logic [7:0] active_d [NUM_CFG_REGS];
    logic       pending_q, pending_d;
    logic       err_addr_q, err_addr_d;
    logic       err_src_q, err_src_d;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({req1_valid, req0_valid}),
        .gnt_o (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        wr = gnt[1] ? cfg_wr_t'{req1_addr, req1_data}
                    : cfg_wr_t'{req0_addr, req0_data};
        acc    = |gnt;
        in_rng = (wr.addr <= MAX_ADDRESS)
              && (wr.addr < 7'(NUM_CFG_REGS));
        widx   = wr.addr[2:0];
        commit = COMMIT_ON_PERIOD && period_start && pending_q;
    end

    // Commit copies the pre-edge shadow; a same-edge write stays pending.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (acc && in_rng) begin
            shadow_d[widx] = wr.data;
            if (COMMIT_ON_PERIOD) pending_d = 1'b1;
            else                  active_d[widx] = wr.data;
        end
    end

    always_comb begin
        err_addr_d = err_addr_q;
        err_src_d  = err_src_q;
        if (err_clear) begin
            err_addr_d = 1'b0;
        end else if (acc && !in_rng) begin
            err_addr_d = 1'b1;
            if (!err_addr_q) err_src_d = gnt[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= '{default: 8'h00};
            active_q   <= '{default: 8'h00};
            pending_q  <= 1'b0;
            err_addr_q <= 1'b0;
            err_src_q  <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            err_addr_q <= err_addr_d;
            err_src_q  <= err_src_d;
        end
    end

    assign en_reg_out_7_0  = active_q[ADDR_EN_OUT_LO[2:0]];
    assign en_reg_out_15_8 = active_q[ADDR_EN_OUT_HI[2:0]];
    assign en_reg_pwm_7_0  = active_q[ADDR_EN_PWM_LO[2:0]];
    assign en_reg_pwm_15_8 = active_q[ADDR_EN_PWM_HI[2:0]];
    assign pwm_duty_cycle  = active_q[ADDR_DUTY[2:0]];
    assign pending         = pending_q;
    assign err_addr        = err_addr_q;
    assign err_src         = err_src_q;

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Scoreboard bench: a commit-on-period and an immediate-commit instance
// share stimulus and are checked against an array-based reference model.
module tb_cfg_write_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [6:0] a0 = '0, a1 = '0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       ps = 1'b0, ec = 1'b0;

    logic       r0_1, r1_1, r0_0, r1_0;
    logic [7:0] o1 [5];
    logic [7:0] o0 [5];
    logic       pend_1, ea_1, es_1;
    logic       pend_0, ea_0, es_0;

    always #5 clk = ~clk;

    cfg_write_arbiter #(.MAX_ADDRESS(7'h04), .COMMIT_ON_PERIOD(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0_1),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1_1),
        .period_start(ps), .err_clear(ec),
        .en_reg_out_7_0(o1[0]), .en_reg_out_15_8(o1[1]),
        .en_reg_pwm_7_0(o1[2]), .en_reg_pwm_15_8(o1[3]),
        .pwm_duty_cycle(o1[4]),
        .pending(pend_1), .err_addr(ea_1), .err_src(es_1)
    );

    cfg_write_arbiter #(.MAX_ADDRESS(7'h04), .COMMIT_ON_PERIOD(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0_0),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1_0),
        .period_start(ps), .err_clear(ec),
        .en_reg_out_7_0(o0[0]), .en_reg_out_15_8(o0[1]),
        .en_reg_pwm_7_0(o0[2]), .en_reg_pwm_15_8(o0[3]),
        .pwm_duty_cycle(o0[4]),
        .pending(pend_0), .err_addr(ea_0), .err_src(es_0)
    );

    typedef struct {
        logic        r0, r1;
        logic [39:0] act1;
        logic        pend1;
        logic [39:0] act0;
        logic        ea, es;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference state
    logic [7:0] m_sh1 [5];
    logic [7:0] m_ac1 [5];
    logic [7:0] m_ac0 [5];
    logic m_pend1, m_ea, m_es;
    int   m_last;

    function automatic logic [39:0] pk(input logic [7:0] a [5]);
        logic [39:0] r;
        for (int i = 0; i < 5; i++) r[8*i +: 8] = a[i];
        return r;
    endfunction

    function void cmp(string n, logic [63:0] got, logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", n, got, want);
        end
    endfunction

    function void model_reset();
        for (int i = 0; i < 5; i++) begin
            m_sh1[i] = 8'h00; m_ac1[i] = 8'h00; m_ac0[i] = 8'h00;
        end
        m_pend1 = 1'b0; m_ea = 1'b0; m_es = 1'b0; m_last = 1;
    endfunction

    task automatic cyc(input bit iv0, input logic [6:0] ia0,
                       input logic [7:0] id0, input bit iv1,
                       input logic [6:0] ia1, input logic [7:0] id1,
                       input bit ips, input bit iec, output int g);
        exp_t e;
        int   wa;
        logic [7:0] wd;
        v0 = iv0; a0 = ia0; d0 = id0;
        v1 = iv1; a1 = ia1; d1 = id1;
        ps = ips; ec = iec;
        g = -1;
        if (iv0 && iv1) g = (m_last == 0) ? 1 : 0;
        else if (iv0)   g = 0;
        else if (iv1)   g = 1;
        e.r0 = (g == 0); e.r1 = (g == 1);
        e.act1 = pk(m_ac1); e.pend1 = m_pend1;
        e.act0 = pk(m_ac0); e.ea = m_ea; e.es = m_es;
        q.push_back(e);
        wa = (g == 1) ? int'(ia1) : int'(ia0);
        wd = (g == 1) ? id1 : id0;
        if (ips && m_pend1) begin
            for (int i = 0; i < 5; i++) m_ac1[i] = m_sh1[i];
            m_pend1 = 1'b0;
        end
        if (g >= 0 && wa <= 4) begin
            m_sh1[wa] = wd; m_pend1 = 1'b1; m_ac0[wa] = wd;
        end
        if (iec) m_ea = 1'b0;
        else if (g >= 0 && wa > 4) begin
            if (!m_ea) m_es = (g == 1);
            m_ea = 1'b1;
        end
        if (g >= 0) m_last = g;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ips, input bit iec);
        int g;
        cyc(0, 7'h0, 8'h0, 0, 7'h0, 8'h0, ips, iec, g);
    endtask

    task automatic rst_dut();
        rst_n = 1'b0;
        v0 = 0; v1 = 0; ps = 0; ec = 0;
        #1;
        cmp("rst_act1", pk(o1), 40'h0);
        cmp("rst_act0", pk(o0), 40'h0);
        cmp("rst_flags", {pend_1, ea_1, es_1, pend_0, ea_0, es_0}, 6'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("ready_c1", {r1_1, r0_1}, {e.r1, e.r0});
            cmp("ready_c0", {r1_0, r0_0}, {e.r1, e.r0});
            cmp("active_c1", pk(o1), e.act1);
            cmp("pending_c1", pend_1, e.pend1);
            cmp("active_c0", pk(o0), e.act0);
            cmp("pending_c0", pend_0, 1'b0);
            cmp("err_c1", {ea_1, es_1}, {e.ea, e.es});
            cmp("err_c0", {ea_0, es_0}, {e.ea, e.es});
        end
    end

    function automatic logic [6:0] raddr();
        if ($urandom_range(5, 0) == 0) return 7'($urandom_range(127, 5));
        return 7'($urandom_range(4, 0));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bit hv0, hv1;
        logic [6:0] ha0, ha1;
        logic [7:0] hd0, hd1;
        model_reset();
        @(posedge clk);
        #1;
        rst_dut();

        // Single write, held until the period boundary
        cyc(1, 7'h4, 8'h80, 0, 7'h0, 8'h0, 0, 0, g);
        cmp("duty_before", o1[4], 8'h00);
        cmp("pend_set", pend_1, 1'b1);
        cmp("duty_imm", o0[4], 8'h80);
        idle(0, 0);
        cmp("duty_hold", o1[4], 8'h00);
        idle(1, 0);
        cmp("duty_commit", o1[4], 8'h80);
        cmp("pend_clr", pend_1, 1'b0);

        // Continuous contention alternates grants
        rst_dut();
        cyc(1, 7'h0, 8'hA0, 1, 7'h1, 8'hB1, 0, 0, g);
        cyc(1, 7'h2, 8'hC2, 1, 7'h1, 8'hB1, 0, 0, g);
        cyc(1, 7'h2, 8'hC2, 1, 7'h3, 8'hD3, 0, 0, g);
        cyc(1, 7'h4, 8'hE4, 1, 7'h3, 8'hD3, 0, 0, g);
        cyc(1, 7'h4, 8'hE4, 0, 7'h0, 8'h00, 0, 0, g);
        idle(1, 0);
        cmp("rr_regs", pk(o1), 40'hE4_D3_C2_B1_A0);

        // Same-address collision: last accepted wins
        rst_dut();
        cyc(1, 7'h2, 8'h11, 1, 7'h2, 8'h22, 0, 0, g);
        cyc(0, 7'h0, 8'h00, 1, 7'h2, 8'h22, 0, 0, g);
        idle(1, 0);
        cmp("collide_pwm_lo", o1[2], 8'h22);

        // Out-of-range writes and the sticky error
        cyc(0, 7'h0, 8'h00, 1, 7'h5, 8'hFF, 0, 0, g);
        cmp("oor_err", {ea_1, es_1}, 2'b11);
        cmp("oor_regs", pk(o1), 40'h00_00_22_00_00);
        cmp("oor_pend", pend_1, 1'b0);
        idle(0, 1);
        cmp("err_cleared", ea_1, 1'b0);
        cyc(1, 7'h6, 8'h00, 0, 7'h0, 8'h00, 0, 1, g);
        cmp("clr_priority", ea_1, 1'b0);
        cyc(1, 7'h9, 8'h00, 0, 7'h0, 8'h00, 0, 0, g);
        cmp("err_src0", {ea_1, es_1}, 2'b10);
        idle(0, 1);

        // Write coincident with period_start waits a full period
        cyc(1, 7'h0, 8'h0F, 0, 7'h0, 8'h00, 1, 0, g);
        cmp("coinc_hold", o1[0], 8'h00);
        cmp("coinc_pend", pend_1, 1'b1);
        idle(0, 0);
        idle(1, 0);
        cmp("coinc_commit", o1[0], 8'h0F);

        // Immediate-commit instance, then reset mid-sequence
        cyc(1, 7'h1, 8'hA5, 0, 7'h0, 8'h00, 0, 0, g);
        cmp("imm_out_hi", o0[1], 8'hA5);
        cmp("imm_c1_hold", o1[1], 8'h00);
        rst_dut();

        hv0 = 0; hv1 = 0;
        ha0 = '0; ha1 = '0; hd0 = '0; hd1 = '0;
        for (int k = 0; k < 3000; k++) begin
            if (!hv0 && $urandom_range(1, 0) == 1) begin
                hv0 = 1; ha0 = raddr(); hd0 = 8'($urandom);
            end
            if (!hv1 && $urandom_range(1, 0) == 1) begin
                hv1 = 1; ha1 = raddr(); hd1 = 8'($urandom);
            end
            if ($urandom_range(499, 0) == 0) begin
                rst_dut();
                hv0 = 0; hv1 = 0;
            end else begin
                cyc(hv0, ha0, hd0, hv1, ha1, hd1,
                    $urandom_range(3, 0) == 0,
                    $urandom_range(15, 0) == 0, g);
                if (g == 0) hv0 = 0;
                if (g == 1) hv1 = 0;
            end
        end
        idle(0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
